// File: rtl/cfg_logic_tile.sv
// Configurable logic tile: N K-input LUT slices, each with an optional output flop,
// programmed through a serial ready/valid shift chain that daisy-chains to the next tile.
module cfg_logic_tile #(
   parameter int K = 5,
   parameter int N = 2
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           cfg_start,
   input  logic           cfg_valid,
   input  logic           cfg_data,
   output logic           cfg_ready,
   output logic           cfg_out,
   output logic           cfg_done,
   input  logic           ce,
   input  logic [N*K-1:0] in,
   output logic [N-1:0]   out
);

   localparam int LUT_SIZE   = 2**K;
   localparam int SLICE_BITS = LUT_SIZE + 1;
   localparam int CFG_BITS   = N * SLICE_BITS;
   localparam int CNT_W      = $clog2(CFG_BITS + 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ACTIVE
   } state_t;

   state_t              state_q, state_d;
   logic [CFG_BITS-1:0] chain_q, chain_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [N-1:0]        q_q, q_d;
   logic [N-1:0]        lut;
   logic [N-1:0]        mode;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_slice
         logic [LUT_SIZE-1:0] truth;
         assign truth    = chain_q[gi*SLICE_BITS +: LUT_SIZE];
         assign mode[gi] = chain_q[gi*SLICE_BITS + LUT_SIZE];
         assign lut[gi]  = truth[in[gi*K +: K]];
         // Outputs are forced low whenever the tile is not fully configured.
         assign out[gi]  = (state_q == ACTIVE) & (mode[gi] ? q_q[gi] : lut[gi]);
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      chain_d = chain_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               state_d = LOAD;
               cnt_d   = '0;
               q_d     = '0;
            end
         end
         LOAD: begin
            // A restart wins over a bit arriving in the same cycle; chain contents survive.
            if (cfg_start) begin
               cnt_d = '0;
               q_d   = '0;
            end else if (cfg_valid) begin
               chain_d = {cfg_data, chain_q[CFG_BITS-1:1]};
               if (cnt_q == CNT_W'(CFG_BITS - 1)) begin
                  state_d = ACTIVE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ACTIVE: begin
            if (cfg_start) begin
               state_d = LOAD;
               cnt_d   = '0;
               q_d     = '0;
            end else if (ce) begin
               q_d = lut;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         chain_q <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         chain_q <= chain_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
      end
   end

   assign cfg_ready = (state_q == LOAD);
   assign cfg_done  = (state_q == ACTIVE);
   assign cfg_out   = chain_q[0];

endmodule

// File: tb/tb_cfg_logic_tile.sv
// Scoreboard bench for cfg_logic_tile: a bit-history model predicts every cycle's
// outputs, and a negedge monitor compares them against the DUT.
module tb_cfg_logic_tile;

   localparam int K        = 5;
   localparam int N        = 2;
   localparam int LUT_SIZE = 2**K;
   localparam int SB       = LUT_SIZE + 1;
   localparam int CFG_BITS = N * SB;

   logic           clock = 1'b0;
   logic           reset_n;
   logic           cfg_start, cfg_valid, cfg_data, ce;
   logic [N*K-1:0] in_v;
   logic           cfg_ready, cfg_out, cfg_done;
   logic [N-1:0]   out_w;

   cfg_logic_tile #(.K(K), .N(N)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .cfg_start(cfg_start),
      .cfg_valid(cfg_valid),
      .cfg_data (cfg_data),
      .cfg_ready(cfg_ready),
      .cfg_out  (cfg_out),
      .cfg_done (cfg_done),
      .ce       (ce),
      .in       (in_v),
      .out      (out_w)
   );

   always #5 clock = ~clock;

   int cyc_cnt = 0;
   always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

   typedef struct {
      int           cyc;
      logic [N-1:0] out;
      logic         rdy;
      logic         done;
      logic         cout;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;

   // Model: the chain is simply the last CFG_BITS accepted bits, oldest at index 0.
   int           mstate;   // 0 unconfigured, 1 loading, 2 active
   int           mcnt;
   bit           hist[$];
   logic [N-1:0] mq;
   bit           bs[$];

   function automatic bit mlut(int s, logic [N*K-1:0] iv);
      int idx;
      idx = int'(iv[s*K +: K]);
      return hist[s*SB + idx];
   endfunction

   task automatic model_reset();
      mstate = 0;
      mcnt   = 0;
      mq     = '0;
      hist.delete();
      for (int i = 0; i < CFG_BITS; i++) hist.push_back(1'b0);
   endtask

   task automatic model_edge();
      if (!reset_n) begin
         model_reset();
      end else if (mstate == 0) begin
         if (cfg_start) begin mstate = 1; mcnt = 0; mq = '0; end
      end else if (mstate == 1) begin
         if (cfg_start) begin
            mcnt = 0;
         end else if (cfg_valid) begin
            hist.push_back(cfg_data);
            void'(hist.pop_front());
            mcnt++;
            if (mcnt == CFG_BITS) begin
               mstate = 2;
               mcnt   = 0;
               $display("config load complete at cycle %0d", cyc_cnt);
            end
         end
      end else begin
         if (cfg_start) begin
            mstate = 1;
            mq     = '0;
         end else if (ce) begin
            for (int s = 0; s < N; s++) mq[s] = mlut(s, in_v);
         end
      end
   endtask

   task automatic push_expect();
      exp_t e;
      e.cyc = cyc_cnt;
      for (int s = 0; s < N; s++)
         e.out[s] = (mstate == 2) ? (hist[s*SB + LUT_SIZE] ? mq[s] : mlut(s, in_v)) : 1'b0;
      e.rdy  = (mstate == 1);
      e.done = (mstate == 2);
      e.cout = hist[0];
      sb.push_back(e);
   endtask

   task automatic check(string name, int cyc, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
   endtask

   always @(negedge clock) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
         exp_t e;
         e = sb.pop_front();
         check("out",       e.cyc, 32'(out_w),     32'(e.out));
         check("cfg_ready", e.cyc, 32'(cfg_ready), 32'(e.rdy));
         check("cfg_done",  e.cyc, 32'(cfg_done),  32'(e.done));
         check("cfg_out",   e.cyc, 32'(cfg_out),   32'(e.cout));
      end
   end

   function automatic logic [N*K-1:0] rand_in(int hi_pct);
      logic [N*K-1:0] v;
      v = (N*K)'($urandom);
      if ($urandom_range(99) < hi_pct) v[2*K-1:K] = '1;
      return v;
   endfunction

   // Drive one cycle's inputs, predict its outputs, then advance across the edge.
   task automatic step(input logic s, input logic v, input logic d, input logic c,
                       input logic [N*K-1:0] i);
      cfg_start = s;
      cfg_valid = v;
      cfg_data  = d;
      ce        = c;
      in_v      = i;
      push_expect();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic build_bs(input logic [31:0] t0, input bit m0,
                           input logic [31:0] t1, input bit m1);
      bs.delete();
      for (int j = 0; j < LUT_SIZE; j++) bs.push_back(t0[j]);
      bs.push_back(m0);
      for (int j = 0; j < LUT_SIZE; j++) bs.push_back(t1[j]);
      bs.push_back(m1);
   endtask

   task automatic send_bits(int count, int gap_pct);
      for (int k = 0; k < count; k++) begin
         while ($urandom_range(99) < gap_pct)
            step(1'b0, 1'b0, 1'($urandom), 1'($urandom), rand_in(20));
         step(1'b0, 1'b1, bs[k], 1'($urandom), rand_in(20));
      end
   endtask

   task automatic run_active(int cycles, int hi_pct);
      for (int k = 0; k < cycles; k++) step(1'b0, 1'($urandom), 1'($urandom), 1'b1, rand_in(hi_pct));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n   = 1'b0;
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = 1'b0;
      ce        = 1'b0;
      in_v      = '0;
      model_reset();
      @(posedge clock);
      #1;
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      reset_n = 1'b1;

      // Unconfigured tile ignores cfg_valid/cfg_data.
      for (int k = 0; k < 10; k++)
         step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), rand_in(0));

      // Parity LUT (combinational) and 5-input AND (registered), continuous valid.
      build_bs(32'h96696996, 1'b0, 32'h80000000, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1, rand_in(0));
      send_bits(CFG_BITS, 0);
      run_active(40, 30);

      // Same bitstream with gaps; cfg_out replays the previous bits.
      step(1'b1, 1'b0, 1'b0, 1'b1, rand_in(0));
      send_bits(CFG_BITS, 40);

      // Registered slice holds with ce low, captures once ce rises.
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b0, {5'h1f, 5'(k)});
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1, {5'h1f, 5'(k)});
      run_active(10, 50);

      // Reconfigure from ACTIVE, restart after 20 bits, then a random full load.
      build_bs($urandom, 1'($urandom), $urandom, 1'($urandom));
      step(1'b1, 1'b1, 1'b1, 1'b1, rand_in(0));
      send_bits(20, 20);
      step(1'b1, 1'b1, 1'b1, 1'b1, rand_in(0));
      build_bs($urandom, 1'($urandom), $urandom, 1'($urandom));
      send_bits(CFG_BITS, 25);
      run_active(30, 30);

      // Asynchronous reset in the middle of a load.
      step(1'b1, 1'b0, 1'b0, 1'b1, rand_in(0));
      build_bs(32'h96696996, 1'b0, 32'h80000000, 1'b1);
      send_bits(30, 0);
      #1;
      reset_n = 1'b0;
      model_reset();
      push_expect();
      step(1'b0, 1'b1, 1'b1, 1'b1, rand_in(0));
      reset_n = 1'b1;
      step(1'b0, 1'b1, 1'b1, 1'b1, rand_in(0));
      step(1'b1, 1'b1, 1'b1, 1'b1, rand_in(0));
      send_bits(CFG_BITS, 0);
      run_active(30, 30);

      @(negedge clock);
      #1;
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
